// File: rtl/risc_pkg.sv
// Shared RISC constants: word/address widths, opcode field and encodings.
// Pure definitions; no timing or flow-control behaviour.
package risc_pkg;

    localparam int AW      = 5;
    localparam int IW      = 13;
    localparam int OPC_MSB = 12;
    localparam int OPC_LSB = 9;

    localparam logic [IW-1:0] NOP = 13'h0000;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_NOT = 4'd6,
        OP_LDI = 4'd7,
        OP_LD  = 4'd8,
        OP_ST  = 4'd9,
        OP_JMP = 4'd10,
        OP_JZ  = 4'd11,
        OP_ROR = 4'd12,
        OP_ROL = 4'd13
    } opcode_t;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_t;

    function automatic logic [3:0] opcode_of(input logic [IW-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/risc_imem_if.sv
// Fetch + loader bundle between the instruction memory and its clients.
// Loader uses valid/ready; fetch is a plain combinational address/data pair.
interface risc_imem_if;
    import risc_pkg::*;

    logic [AW-1:0] pc;
    logic [IW-1:0] instruction;
    logic          ld_start;
    logic          ld_valid;
    logic [IW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          ld_done;
    logic          busy;
    logic [AW:0]   ld_count;

    modport slave (
        input  pc, ld_start, ld_valid, ld_data, ld_last,
        output instruction, ld_ready, ld_done, busy, ld_count
    );

    modport master (
        output pc, ld_start, ld_valid, ld_data, ld_last,
        input  instruction, ld_ready, ld_done, busy, ld_count
    );
endinterface

// File: rtl/risc_imem_loader.sv
// Load sequencer: IDLE/LOAD/DONE FSM producing sequential write strobes from address 0.
// Ready only in LOAD; ld_valid low stalls indefinitely; terminates on ld_last or top address.
module risc_imem_loader #(
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_start_i,
    input  logic          ld_valid_i,
    input  logic          ld_last_i,
    output logic          we_o,
    output logic [AW-1:0] waddr_o,
    output logic          busy_o,
    output logic          ld_ready_o,
    output logic          ld_done_o,
    output logic [AW:0]   ld_count_o
);
    import risc_pkg::*;

    ld_state_t     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LD_IDLE;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        we_o       = 1'b0;
        busy_o     = 1'b0;
        ld_ready_o = 1'b0;
        ld_done_o  = 1'b0;
        unique case (state_q)
            LD_IDLE: begin
                if (ld_start_i) begin
                    state_d = LD_LOAD;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            LD_LOAD: begin
                busy_o     = 1'b1;
                ld_ready_o = 1'b1;
                if (ld_valid_i) begin
                    we_o    = 1'b1;
                    addr_d  = addr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    // The top word ends the load so the counter never wraps onto word 0.
                    if (ld_last_i || (addr_q == AW'(DEPTH - 1))) begin
                        state_d = LD_DONE;
                    end
                end
            end
            LD_DONE: begin
                ld_done_o = 1'b1;
                state_d   = LD_IDLE;
            end
            default: state_d = LD_IDLE;
        endcase
    end

    assign waddr_o    = addr_q;
    assign ld_count_o = count_q;

endmodule

// File: rtl/risc_imem.sv
// Instruction memory: flop array with zero-latency fetch, written through the loader port.
// Fetch returns NOP while a load is in flight; loader backpressure comes from risc_imem_loader.
module risc_imem #(
    parameter int AW    = risc_pkg::AW,
    parameter int DEPTH = 32,
    parameter int IW    = risc_pkg::IW
) (
    input  logic        clk,
    input  logic        rst_n,
    risc_imem_if.slave  bus
);
    import risc_pkg::*;

    logic [IW-1:0] mem_q [DEPTH];
    logic          we;
    logic [AW-1:0] waddr;
    logic          busy;

    risc_imem_loader #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_start_i (bus.ld_start),
        .ld_valid_i (bus.ld_valid),
        .ld_last_i  (bus.ld_last),
        .we_o       (we),
        .waddr_o    (waddr),
        .busy_o     (busy),
        .ld_ready_o (bus.ld_ready),
        .ld_done_o  (bus.ld_done),
        .ld_count_o (bus.ld_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= NOP;
            end
        end else if (we) begin
            mem_q[waddr] <= bus.ld_data;
        end
    end

    // Masking during a load keeps the fetch unit from seeing a half-written program.
    assign bus.instruction = busy ? NOP : mem_q[bus.pc];
    assign bus.busy        = busy;

endmodule

// File: tb/tb_risc_imem.sv
// Directed bench for risc_imem: table-driven load/fetch vectors plus hand-written corner sequences.
module tb_risc_imem;

    logic clk;
    logic rst_n;
    int   nvec;
    int   nerr;
    int   done_cnt;

    risc_imem_if bus ();

    risc_imem dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ld_done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [12:0] data;
        logic        last;
        logic [5:0]  exp_count;
    } ld_vec_t;

    typedef struct {
        logic [4:0]  pc;
        logic [12:0] exp_instr;
    } fetch_vec_t;

    ld_vec_t    ld_tab [13];
    fetch_vec_t f_tab  [14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fetch_check(input string name, input logic [4:0] pc, input logic [12:0] exp);
        bus.pc = pc;
        #1;
        check(name, 32'(bus.instruction), 32'(exp));
    endtask

    initial begin
        logic [12:0] words [13];
        nvec = 0;
        nerr = 0;
        done_cnt = 0;
        words = '{13'h0208, 13'h05f1, 13'h06aa, 13'h08e3, 13'h0b24, 13'h0d45, 13'h0f86,
                  13'h11c7, 13'h1200, 13'h1441, 13'h1682, 13'h18c3, 13'h1b04};
        for (int i = 0; i < 13; i++) begin
            ld_tab[i].data      = words[i];
            ld_tab[i].last      = (i == 12);
            ld_tab[i].exp_count = 6'(i + 1);
        end
        for (int i = 0; i < 13; i++) begin
            f_tab[i].pc        = 5'(i);
            f_tab[i].exp_instr = words[i];
        end
        f_tab[13].pc        = 5'd13;
        f_tab[13].exp_instr = 13'h0000;

        rst_n        = 1'b0;
        bus.pc       = '0;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.ld_last  = 1'b0;
        #1;

        // Reset state and fetch sweep
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready", 32'(bus.ld_ready), 32'd0);
        check("rst_done", 32'(bus.ld_done), 32'd0);
        check("rst_count", 32'(bus.ld_count), 32'd0);
        for (int p = 0; p < 32; p++) fetch_check("rst_fetch", 5'(p), 13'h0000);
        step();
        rst_n = 1'b1;
        step();

        // ld_valid while idle must not write
        bus.ld_valid = 1'b1;
        bus.ld_data  = 13'h1fff;
        step();
        check("idle_ready", 32'(bus.ld_ready), 32'd0);
        step();
        bus.ld_valid = 1'b0;
        fetch_check("idle_nowrite0", 5'd0, 13'h0000);
        fetch_check("idle_nowrite1", 5'd1, 13'h0000);

        // Load of 13 words with ld_last, gap and ignored ld_start mid-load
        bus.ld_start = 1'b1;
        step();
        bus.ld_start = 1'b0;
        check("load_busy", 32'(bus.busy), 32'd1);
        check("load_ready", 32'(bus.ld_ready), 32'd1);
        check("load_count0", 32'(bus.ld_count), 32'd0);
        for (int i = 0; i < 13; i++) begin
            if (i == 6) begin
                bus.ld_valid = 1'b0;
                bus.ld_start = 1'b1;
                step();
                bus.ld_start = 1'b0;
                step();
                step();
                check("gap_ready", 32'(bus.ld_ready), 32'd1);
                check("gap_count", 32'(bus.ld_count), 32'd6);
                fetch_check("busy_fetch", 5'd0, 13'h0000);
            end
            bus.ld_valid = 1'b1;
            bus.ld_data  = ld_tab[i].data;
            bus.ld_last  = ld_tab[i].last;
            step();
            check("load_count", 32'(bus.ld_count), 32'(ld_tab[i].exp_count));
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        check("done_pulse", 32'(bus.ld_done), 32'd1);
        check("done_busy", 32'(bus.busy), 32'd0);
        check("done_ready", 32'(bus.ld_ready), 32'd0);

        // ld_start sampled in DONE is ignored
        bus.ld_start = 1'b1;
        step();
        bus.ld_start = 1'b0;
        check("post_done", 32'(bus.ld_done), 32'd0);
        check("start_in_done_busy", 32'(bus.busy), 32'd0);
        check("count_hold", 32'(bus.ld_count), 32'd13);
        step();
        check("done_once", 32'(done_cnt), 32'd1);
        for (int i = 0; i < 14; i++) fetch_check("fetch_tab", f_tab[i].pc, f_tab[i].exp_instr);

        // Auto-terminate at the top address
        bus.ld_start = 1'b1;
        step();
        bus.ld_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 13'h1000 | 13'(i);
            step();
        end
        check("auto_done", 32'(bus.ld_done), 32'd1);
        check("auto_count", 32'(bus.ld_count), 32'd32);
        bus.ld_data = 13'h1fff;
        check("auto_33_ready", 32'(bus.ld_ready), 32'd0);
        step();
        bus.ld_valid = 1'b0;
        step();
        check("auto_busy", 32'(bus.busy), 32'd0);
        fetch_check("auto_mem0", 5'd0, 13'h1000);
        fetch_check("auto_mem13", 5'd13, 13'h100d);
        fetch_check("auto_mem31", 5'd31, 13'h101f);
        check("auto_done_cnt", 32'(done_cnt), 32'd2);

        // Reset in the middle of a load
        bus.ld_start = 1'b1;
        step();
        bus.ld_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 13'h0aaa;
            step();
        end
        check("mid_busy", 32'(bus.busy), 32'd1);
        check("mid_count", 32'(bus.ld_count), 32'd5);
        rst_n = 1'b0;
        #1;
        bus.ld_valid = 1'b0;
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_done", 32'(bus.ld_done), 32'd0);
        check("mrst_count", 32'(bus.ld_count), 32'd0);
        fetch_check("mrst_mem0", 5'd0, 13'h0000);
        fetch_check("mrst_mem4", 5'd4, 13'h0000);
        fetch_check("mrst_mem31", 5'd31, 13'h0000);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        check("mrst_idle", 32'(bus.ld_ready), 32'd0);
        check("mrst_no_done", 32'(done_cnt), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/risc_imem.md
# risc_imem

Program/instruction memory for the RISC core: the responder on the fetch interface driven by `risc_iunit`. It returns the 13-bit instruction at the PC presented by the instruction unit, and provides a handshaked loader port so a host or bench can write a program before or between runs. While a load is in progress the fetch port returns NOP, so the instruction unit never latches a partially written program.

## Interface
Parameters:
- `AW`, 5: address width; PC width.
- `DEPTH`, 32: number of words; must equal 2**AW.
- `IW`, 13: instruction width.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `pc`  in  AW: fetch address from `risc_iunit`.
- `instruction`  out  IW: fetched word, driven to `risc_iunit.instruction`.
- `ld_start`  in  1: one-cycle request to begin a load at address 0.
- `ld_valid`  in  1: loader data valid.
- `ld_data`  in  IW: word to write.
- `ld_last`  in  1: qualifies the final word of a load; sampled with `ld_valid`.
- `ld_ready`  out  1: memory accepts a word this cycle.
- `ld_done`  out  1: one-cycle pulse when a load completes.
- `busy`  out  1: load in progress.
- `ld_count`  out  AW+1: number of words written by the last or current load.

## Operation
- Storage is a DEPTH x IW flop array. Reset clears every word to 13'h0000, which is NOP (opcode field [12:9] = 0).
- Fetch is combinational: `instruction = busy ? 13'h0000 : mem[pc]`. Any `pc` value is legal; no out-of-range check is needed because DEPTH = 2**AW.
- Loader FSM states: IDLE, LOAD, DONE.
  - IDLE: `ld_ready=0`, `busy=0`. A `ld_start` moves to LOAD and clears the address counter and `ld_count`. `ld_valid` is ignored in IDLE.
  - LOAD: `ld_ready=1`, `busy=1`. Each cycle with `ld_valid=1` writes `ld_data` to `mem[addr]`, then increments `addr` and `ld_count`.
    - Go to DONE when the accepted word has `ld_last=1`, or when the accepted word is at addr = DEPTH-1 (auto-terminate; no wrap).
    - `ld_start` in LOAD is ignored.
  - DONE: `ld_done=1` for exactly one cycle, `busy=0`, `ld_ready=0`, then go to IDLE.
- Words beyond the last written address keep their previous contents.
- `ld_count` holds its value until the next `ld_start`.
- Reset mid-load: state returns to IDLE, the array is cleared, and no `ld_done` pulse is issued.

## Timing
- Reset values: `instruction=13'h0000`, `ld_ready=0`, `ld_done=0`, `busy=0`, `ld_count=0`, FSM in IDLE.
- Fetch latency is 0 cycles, which lets `risc_iunit` register `ir` on the same edge its PC selects.
- A write is visible on `instruction` the cycle after the write edge, once `busy` has dropped.
- `ld_start` at edge N: `busy` and `ld_ready` go high after N, and the first word can be accepted at edge N+1.
- Last word accepted at edge M: DONE state (`ld_done=1`, `busy=0`) after M, IDLE after M+1. A new `ld_start` is honoured at M+2 or later; one sampled in DONE is ignored.
- `ld_valid=0` in LOAD stalls with no write; there is no timeout.

## Structure
- Shared package `risc_pkg`: `IW`, `AW`, the opcode field position [12:9], and the constant `NOP = 13'h0000`. The opcode enumeration (add=1 … rol=13) is shared with `risc_iunit`.
- One sub-module, `risc_imem_loader`: the FSM, address counter and `ld_count`, producing `we`/`waddr`. The top level holds the array and the fetch mux.

## Test plan
- Reset and fetch: assert reset, sweep `pc` 0..31 -> `instruction=13'h0000` everywhere, `busy=0`, `ld_count=0`.
- Load with `ld_last`: load words 13'h0208, 05f1, 06aa, 08e3, 0b24, 0d45, 0f86, 11c7, 1200, 1441, 1682, 18c3, 1b04, with `ld_last` on the 13th -> `ld_done` pulses once and `ld_count=13`. Then `pc=0..12` returns those words, and `pc=13` returns 0000.
- Stall, and fetch during load: gap `ld_valid` for 3 cycles mid-load -> no write during the gap and `ld_ready` stays 1. `instruction=0000` for any `pc` while `busy=1`.
- Auto-terminate: send 32 words, none with `ld_last` -> `ld_done` after word 31, `ld_count=32`. A 33rd `ld_valid` word is not accepted (`ld_ready=0`) and `mem[0]` is unchanged.
- Ignored controls: `ld_start` during LOAD keeps `addr` unchanged. `ld_valid` in IDLE writes nothing. `ld_start` in DONE has no effect.
- Reset mid-load: assert `rst_n=0` after 5 words -> FSM in IDLE, all words read 0000, no `ld_done` pulse.
